// File: rtl/piano_pkg.sv
// Shared types and constants for the piano datapath: UART receiver states,
// default line settings and the volume/note field positions in a received byte.
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    localparam int VOL_MSB  = 7;
    localparam int VOL_LSB  = 5;
    localparam int NOTE_MSB = 4;
    localparam int NOTE_LSB = 0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the
// value both flops take in reset so the output never shows a false edge.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iD,
    output logic oQ
);

    logic meta;

    // NOTE: non-blocking assignments for every registered signal, so both
    // flops sample the pre-edge values and form a real two-stage chain.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            meta <= RST_VAL;
            oQ   <= RST_VAL;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes iRX, samples each bit at its midpoint and
// delivers the byte with a one-cycle strobe, a toggle flag and a frame-error pulse.
module uart_byte_rx
    import piano_pkg::*;
#(
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int BAUD        = DEF_BAUD,
    parameter int BIT_CYCLES  = CLK_FREQ / BAUD,
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRX,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oState,
    output logic       oFrameErr,
    output logic       oBusy
);

    localparam int              CW        = $clog2(BIT_CYCLES + 1);
    // Loads are one less than the period because the zero count is the sample cycle.
    localparam logic [CW-1:0]   BIT_LOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic            rx_s;
    rx_state_t       state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic [7:0]      data_d;
    logic            valid_d, flag_d, ferr_d;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .iClk (iClk),
        .iRst (iRst),
        .iD   (iRX),
        .oQ   (rx_s)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            oData     <= '0;
            oValid    <= 1'b0;
            oState    <= 1'b0;
            oFrameErr <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shift     <= shift_d;
            oData     <= data_d;
            oValid    <= valid_d;
            oState    <= flag_d;
            oFrameErr <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        data_d    = oData;
        valid_d   = 1'b0;
        flag_d    = oState;
        ferr_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else if (!rx_s) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = BIT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    shift_d[bit_idx] = rx_s;
                    cnt_d            = BIT_LOAD;
                    if (bit_idx == 3'd7) state_d   = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    // Leave at mid-stop so a start bit right after the stop bit is caught.
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shift;
                        valid_d = 1'b1;
                        flag_d  = ~oState;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at BIT_CYCLES=10, HALF_CYCLES=5: single byte,
// start glitch, frame error, back-to-back frames, mid-frame reset, field slicing.
module tb_uart_byte_rx;
    import piano_pkg::*;

    logic       clk = 1'b0;
    logic       iRst, iRX;
    logic [7:0] oData;
    logic       oValid, oState, oFrameErr, oBusy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         valid_cycs[$];
    logic [7:0] valid_data[$];
    logic       valid_flag[$];
    int         ferr_cycs[$];
    int         both_high = 0;

    always #5 clk = ~clk;

    uart_byte_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .iClk      (clk),
        .iRst      (iRst),
        .iRX       (iRX),
        .oData     (oData),
        .oValid    (oValid),
        .oState    (oState),
        .oFrameErr (oFrameErr),
        .oBusy     (oBusy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with its cycle so the tasks can check timing afterwards.
    always @(negedge clk) begin
        if (oValid) begin
            valid_cycs.push_back(cyc);
            valid_data.push_back(oData);
            valid_flag.push_back(oState);
        end
        if (oFrameErr) ferr_cycs.push_back(cyc);
        if (oValid && oFrameErr) both_high++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 100-cycle frame; returns with the line still at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
        iRX  = 1'b0;
        fall = cyc;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            iRX = b[i];
            repeat (10) tick();
        end
        iRX = stop;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        iRX  = 1'b1;
        repeat (3) tick();
        checks++; if (oData !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", oData); end
        checks++; if (oValid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
        checks++; if (oState !== 1'b0)   begin errors++; $display("FAIL reset_state: got %b expected 0", oState); end
        checks++; if (oFrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", oFrameErr); end
        checks++; if (oBusy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
        iRst = 1'b0;
        repeat (3) tick();
        checks++; if (oBusy !== 1'b0)    begin errors++; $display("FAIL idle_busy: got %b expected 0", oBusy); end
    endtask

    task automatic test_single();
        int n0 = valid_cycs.size();
        int f0 = ferr_cycs.size();
        int fall;
        send_frame(8'hA5, 1'b1, fall);
        iRX = 1'b1;
        repeat (10) tick();
        checks++; if (valid_cycs.size() - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", valid_cycs.size() - n0); end
        checks++; if (valid_cycs[n0] - fall !== 98) begin errors++; $display("FAIL single_latency: got %0d expected 98", valid_cycs[n0] - fall); end
        checks++; if (valid_data[n0] !== 8'hA5)     begin errors++; $display("FAIL single_data: got %h expected a5", valid_data[n0]); end
        checks++; if (oState !== 1'b1)              begin errors++; $display("FAIL single_state: got %b expected 1", oState); end
        checks++; if (ferr_cycs.size() - f0 !== 0)  begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cycs.size() - f0); end
        checks++; if (oBusy !== 1'b0)               begin errors++; $display("FAIL single_busy: got %b expected 0", oBusy); end
    endtask

    task automatic test_glitch();
        int n0 = valid_cycs.size();
        int f0 = ferr_cycs.size();
        iRX = 1'b0;
        repeat (3) tick();
        iRX = 1'b1;
        repeat (2) tick();
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", oBusy); end
        repeat (20) tick();
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", oBusy); end
        checks++; if (valid_cycs.size() - n0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cycs.size() - n0); end
        checks++; if (ferr_cycs.size() - f0 !== 0)  begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cycs.size() - f0); end
        checks++; if (oData !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", oData); end
    endtask

    task automatic test_frame_err();
        int n0 = valid_cycs.size();
        int f0 = ferr_cycs.size();
        int fall;
        send_frame(8'h3C, 1'b0, fall);
        iRX = 1'b1;
        repeat (30) tick();
        checks++; if (ferr_cycs.size() - f0 !== 1)  begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cycs.size() - f0); end
        checks++; if (ferr_cycs[f0] - fall !== 98)  begin errors++; $display("FAIL ferr_latency: got %0d expected 98", ferr_cycs[f0] - fall); end
        checks++; if (valid_cycs.size() - n0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cycs.size() - n0); end
        checks++; if (oData !== 8'hA5)  begin errors++; $display("FAIL ferr_data: got %h expected a5", oData); end
        checks++; if (oState !== 1'b1)  begin errors++; $display("FAIL ferr_state: got %b expected 1", oState); end
    endtask

    task automatic test_back_to_back();
        int n0 = valid_cycs.size();
        int f1, f2;
        send_frame(8'h00, 1'b1, f1);
        send_frame(8'hFF, 1'b1, f2);
        iRX = 1'b1;
        repeat (10) tick();
        checks++; if (valid_cycs.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cycs.size() - n0); end
        checks++; if (valid_cycs[n0] - f1 !== 98)   begin errors++; $display("FAIL b2b_latency: got %0d expected 98", valid_cycs[n0] - f1); end
        checks++; if (valid_cycs[n0+1] - valid_cycs[n0] !== 100) begin errors++; $display("FAIL b2b_spacing: got %0d expected 100", valid_cycs[n0+1] - valid_cycs[n0]); end
        checks++; if (valid_data[n0] !== 8'h00)   begin errors++; $display("FAIL b2b_data0: got %h expected 00", valid_data[n0]); end
        checks++; if (valid_data[n0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", valid_data[n0+1]); end
        checks++; if (valid_flag[n0] !== 1'b0)    begin errors++; $display("FAIL b2b_state0: got %b expected 0", valid_flag[n0]); end
        checks++; if (valid_flag[n0+1] !== 1'b1)  begin errors++; $display("FAIL b2b_state1: got %b expected 1", valid_flag[n0+1]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h5A;
        int n0 = valid_cycs.size();
        int f0 = ferr_cycs.size();
        int fall;
        iRX = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            iRX = b[i];
            repeat (10) tick();
        end
        iRX = b[4];
        repeat (5) tick();
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", oBusy); end
        iRst = 1'b1;
        iRX  = 1'b1;
        repeat (2) tick();
        checks++; if (oData !== 8'h00)    begin errors++; $display("FAIL mid_rst_data: got %h expected 00", oData); end
        checks++; if (oState !== 1'b0)    begin errors++; $display("FAIL mid_rst_state: got %b expected 0", oState); end
        checks++; if (oValid !== 1'b0)    begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", oValid); end
        checks++; if (oFrameErr !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr: got %b expected 0", oFrameErr); end
        checks++; if (oBusy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", oBusy); end
        iRst = 1'b0;
        repeat (3) tick();
        checks++; if (valid_cycs.size() - n0 !== 0 || ferr_cycs.size() - f0 !== 0) begin
            errors++; $display("FAIL mid_no_pulse: got %0d valid %0d ferr expected 0 0",
                               valid_cycs.size() - n0, ferr_cycs.size() - f0);
        end
        send_frame(8'h81, 1'b1, fall);
        iRX = 1'b1;
        repeat (10) tick();
        checks++; if (valid_cycs.size() - n0 !== 1) begin errors++; $display("FAIL after_rst_count: got %0d expected 1", valid_cycs.size() - n0); end
        checks++; if (valid_cycs[n0] - fall !== 98) begin errors++; $display("FAIL after_rst_latency: got %0d expected 98", valid_cycs[n0] - fall); end
        checks++; if (oData !== 8'h81)  begin errors++; $display("FAIL after_rst_data: got %h expected 81", oData); end
        checks++; if (oState !== 1'b1)  begin errors++; $display("FAIL after_rst_state: got %b expected 1", oState); end
    endtask

    task automatic test_fields();
        int n0 = valid_cycs.size();
        int fall;
        logic [7:0] d;
        send_frame(8'hE3, 1'b1, fall);
        iRX = 1'b1;
        repeat (10) tick();
        d = valid_data[n0];
        checks++; if (valid_cycs.size() - n0 !== 1) begin errors++; $display("FAIL fields_count: got %0d expected 1", valid_cycs.size() - n0); end
        checks++; if (d[VOL_MSB:VOL_LSB] !== 3'b111) begin errors++; $display("FAIL fields_vol: got %b expected 111", d[VOL_MSB:VOL_LSB]); end
        checks++; if (d[NOTE_MSB:NOTE_LSB] !== 5'd3) begin errors++; $display("FAIL fields_note: got %0d expected 3", d[NOTE_MSB:NOTE_LSB]); end
        checks++; if (valid_flag[n0] !== 1'b0) begin errors++; $display("FAIL fields_state: got %b expected 0", valid_flag[n0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_fields();
        checks++; if (both_high !== 0) begin errors++; $display("FAIL valid_and_ferr_overlap: got %0d expected 0", both_high); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
